// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: pipeline sequencing for the 5-stage core (load-use, redirect, fetch stall, dmem freeze)
module hazard_pipe_ctrl #(
    parameter int CNT_W            = 32,
    parameter int REDIRECT_PENALTY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic [1:0] {RUN = 2'd0, REDIRECT = 2'd1, FREEZE = 2'd2} state_t;
    localparam logic [3:0] PEN_M1 = 4'(REDIRECT_PENALTY - 1);
    state_t state, state_nxt, saved, saved_nxt, eff;
    logic [3:0] rcnt, rcnt_nxt;
    logic load_use, flush_inc;
    assign ctrl_state = state;
    always_comb begin
        load_use = ex_mem_read && ex_rd != 5'd0 &&
                   ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        eff = (state == FREEZE) ? saved : state;
        pc_write_en = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold = 1'b0;
        state_nxt = RUN;
        saved_nxt = saved;
        rcnt_nxt = rcnt;
        flush_inc = 1'b0;
        if (reset) begin
            pc_write_en = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (dmem_busy) begin
            // EX is held, so a pending redirect simply re-presents after the freeze
            pc_write_en = 1'b0;
            if_id_write_en = 1'b0;
            pipe_hold = 1'b1;
            state_nxt = FREEZE;
            saved_nxt = eff;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc = 1'b1;
            state_nxt = (REDIRECT_PENALTY > 1) ? REDIRECT : RUN;
            rcnt_nxt = (REDIRECT_PENALTY > 1) ? PEN_M1 : rcnt;
        end else if (eff == REDIRECT) begin
            if_id_flush = 1'b1;
            pc_write_en = imem_ready;
            rcnt_nxt = imem_ready ? rcnt - 4'd1 : rcnt;
            state_nxt = (imem_ready && rcnt == 4'd1) ? RUN : REDIRECT;
        end else if (load_use) begin
            pc_write_en = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!imem_ready) begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            saved <= RUN;
            rcnt <= 4'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state <= state_nxt;
            saved <= saved_nxt;
            rcnt <= rcnt_nxt;
            if (!pc_write_en && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && !(&flush_events)) flush_events <= flush_events + CNT_W'(1);
        end
    end
endmodule
